output_unit: RTL and testbench

Output side of the core's `OUT` instruction path. Accepts bytes from the execute phase via `out_req`/`out_data`, buffers them, and serialises them onto a UART TX line (8N1, LSB first). Back-pressures the core with `out_busy`, which the core's stall logic must honour. Sits between the core and the board pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/byte_fifo.sv | 73 +++++++
 rtl/output_unit.sv | 179 +++++++++++++++++
 tb/tb_output_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the OUT-instruction UART path.
//   tx_state_t          - transmitter FSM encoding
//   UART_DATA_W         - payload bits per frame
//   CLK_PER_BIT_DEFAULT - 100 MHz / 115200 baud
//   REG_W               - core register width (same value as common_params.h)
package uart_pkg;

    localparam int REG_W               = 32;
    localparam int UART_DATA_W         = 8;
    localparam int CLK_PER_BIT_DEFAULT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with occupancy count.
//   clk, rst        - clock, synchronous active-high reset
//   push, push_data - write request / byte (ignored when full)
//   pop, pop_data   - read request / head byte (pop_data valid when !empty)
//   full, empty     - occupancy flags
//   count           - number of stored bytes, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap by overflow.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] push_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]            count_q, count_d;
    logic                   push_ok, pop_ok;

    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // simultaneous push and pop leaves occupancy unchanged
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;  // storage needs no reset; pointers/count define validity
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/output_unit.sv
// output_unit: buffers bytes from the core's OUT instruction and sends them
// as 8N1 UART frames, LSB first.
//   clk, rst  - clock, synchronous active-high reset
//   out_req   - execute phase wants to output out_data[7:0] this cycle
//   out_data  - REG_W-bit word; upper bits are dropped
//   out_busy  - buffer full, byte not taken; core must hold its request
//   txd       - registered serial line, idle high
//   tx_idle   - buffer empty and no frame in flight
// Build option OUTPUT_UNIT_FIFO_EN: defined -> FIFO_DEPTH-entry byte_fifo;
// undefined -> single holding register (FIFO_DEPTH unused). Serial timing
// is the same in both builds.
module output_unit
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_req,
    input  logic [REG_W-1:0] out_data,
    output logic             out_busy,
    output logic             txd,
    output logic             tx_idle
);

    localparam int            TW       = $clog2(CLK_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLK_PER_BIT - 1);

    logic                         buf_full, buf_empty;
    logic [UART_DATA_W-1:0]       buf_data;
    logic [UART_DATA_W-1:0]       tx_byte;
    logic [REG_W-UART_DATA_W-1:0] out_data_unused;
    logic                         push, pop;

    tx_state_t              state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic                   txd_q, txd_d;

    assign tx_byte         = out_data[UART_DATA_W-1:0];
    assign out_data_unused = out_data[REG_W-1:UART_DATA_W];

    // busy comes from registered occupancy only, so the core's stall path
    // never loops back through out_req
    assign out_busy = buf_full;
    assign push     = out_req && !buf_full;
    assign pop      = (state_q == IDLE) && !buf_empty;
    assign tx_idle  = (state_q == IDLE) && buf_empty;
    assign txd      = txd_q;

`ifdef OUTPUT_UNIT_FIFO_EN
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (tx_byte),
        .pop       (pop),
        .pop_data  (buf_data),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (fifo_count_unused)
    );
`else
    localparam int fifo_depth_unused = FIFO_DEPTH;

    logic                   hold_full_q, hold_full_d;
    logic [UART_DATA_W-1:0] hold_data_q, hold_data_d;

    // push needs !full and pop needs full, so they never coincide
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (pop) begin
            hold_full_d = 1'b0;
        end
        if (push) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign buf_full  = hold_full_q;
    assign buf_empty = !hold_full_q;
    assign buf_data  = hold_data_q;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    // next state: timer reloads on every state or bit change
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                if (!buf_empty) begin
                    state_d = START;
                    timer_d = BIT_LAST;
                    shift_d = buf_data;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    state_d   = DATA;
                    timer_d   = BIT_LAST;
                    bit_idx_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // output: txd is registered, so it is decoded from the next state
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_output_unit.sv
// tb_output_unit: directed bench for output_unit with CLK_PER_BIT=4 and
// FIFO_DEPTH=4. Buffer capacity follows OUTPUT_UNIT_FIFO_EN (4 or 1).
module tb_output_unit;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef OUTPUT_UNIT_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_req = 1'b0;
    logic [31:0] out_data = '0;
    logic        out_busy, txd, tx_idle;

    output_unit #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_req  (out_req),
        .out_data (out_data),
        .out_busy (out_busy),
        .txd      (txd),
        .tx_idle  (tx_idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int frame_err = 0;
    logic [7:0] rx_q[$];

    // line receiver: samples mid-bit, drops frames cut by reset
    logic [7:0] mon_b;
    logic       mon_ok;
    always begin
        @(negedge clk);
        if (!rst && txd === 1'b0) begin
            mon_ok = 1'b1;
            mon_b  = '0;
            for (int k = 1; k < 10*CPB && mon_ok; k++) begin
                @(negedge clk);
                if (rst) mon_ok = 1'b0;
                else if (k % CPB == CPB/2) begin
                    if (k/CPB == 0) begin
                        if (txd !== 1'b0) frame_err++;
                    end else if (k/CPB == 9) begin
                        if (txd !== 1'b1) frame_err++;
                    end else begin
                        mon_b[k/CPB-1] = txd;
                    end
                end
            end
            if (mon_ok) rx_q.push_back(mon_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // core model: hold request until a cycle where busy is low
    task automatic put(input logic [31:0] d);
        int g = 0;
        out_req  = 1'b1;
        out_data = d;
        while (out_busy && g < 1000) begin
            tick();
            g++;
        end
        tick();
        out_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (!tx_idle && g < 2000) begin
            tick();
            g++;
        end
        chk(tag, tx_idle, 1'b1);
    endtask

    logic [9:0]  frame;
    logic [39:0] obs40, exp40;
    logic [7:0]  t4_bytes [6];
    int          idx, c0;
    logic        acc, stayed;

    initial begin
        t4_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        // reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", out_busy, 1'b0);
        chk("rst_idle", tx_idle, 1'b1);
        rst = 1'b0;
        tick();

        // single byte 0x41, cycle-exact frame
        out_req = 1'b1; out_data = 32'h0000_0041;
        tick();
        out_req = 1'b0;
        chk("t1_idle_after_accept", tx_idle, 1'b0);
        chk("t1_txd_before_start", txd, 1'b1);
        chk("t1_busy_after_accept", out_busy, CAP == 1);
        frame = {1'b1, 8'h41, 1'b0};
        for (int c = 0; c < 10*CPB; c++) begin
            tick();
            obs40[c] = txd;
            exp40[c] = frame[c/CPB];
        end
        chk("t1_frame_wave", obs40, exp40);
        tick();
        chk("t1_idle_end", tx_idle, 1'b1);
        chk("t1_txd_end", txd, 1'b1);
        chk("t1_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t1_rx_byte", rx_q.pop_front(), 8'h41);

        // upper bits dropped
        put(32'hDEAD_BE55);
        wait_idle("t2_drain");
        chk("t2_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t2_rx_byte", rx_q.pop_front(), 8'h55);

        // fill to full, push at full during pop; n counts negedges from first request
        idx = 0; acc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (acc) idx++;
            if (n == 1)  chk("t3_busy_n1", out_busy, CAP == 1);
            if (n == 2)  chk("t3_busy_n2", out_busy, 1'b0);
            if (n == 5)  chk("t3_busy_full", out_busy, 1'b1);
            if (n == 42) begin
                chk("t3_busy_idle_pop", out_busy, 1'b1);
                chk("t3_txd_idle_gap", txd, 1'b1);
            end
            if (n == 43) begin
                chk("t3_busy_after_pop", out_busy, 1'b0);
                chk("t3_txd_start2", txd, 1'b0);
            end
            if (n == 44) chk("t3_busy_refull", out_busy, 1'b1);
            if (idx >= 6) break;
            out_req  = 1'b1;
            out_data = {24'h0, t4_bytes[idx]};
            acc      = !out_busy;
            tick();
        end
        out_req = 1'b0;
        chk("t3_all_accepted", idx, 6);
        wait_idle("t3_drain");
        chk("t3_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6 && rx_q.size() > 0; i++) begin
            chk("t3_rx_order", rx_q.pop_front(), t4_bytes[i]);
        end

        // reset during data bit 3 of 0xA5 with bytes queued
        c0 = cyc;
        put(32'h0000_00A5);
        put(32'h0000_0011);
`ifdef OUTPUT_UNIT_FIFO_EN
        put(32'h0000_0022);
`endif
        while (cyc < c0 + 19) tick();
        chk("t4_bit3_low", txd, 1'b0);
        chk("t4_busy_midframe", tx_idle, 1'b0);
        rst = 1'b1;
        tick();
        chk("t4_rst_txd", txd, 1'b1);
        chk("t4_rst_idle", tx_idle, 1'b1);
        chk("t4_rst_busy", out_busy, 1'b0);
        tick();
        rst = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd !== 1'b1 || tx_idle !== 1'b1) stayed = 1'b0;
        end
        chk("t4_quiet_after_rst", stayed, 1'b1);
        chk("t4_no_frames", rx_q.size(), 0);
        put(32'h0000_003C);
        wait_idle("t4_drain");
        chk("t4_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("t4_rx_byte", rx_q.pop_front(), 8'h3C);

        chk("framing_errors", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
